// File: rtl/irrigation_timer_sequencer.sv
// Irrigation countdown sequencer: loads a minutes preset on start, counts down
// in 10-second steps while driving the valve, with pause on sensor conflict and button abort.
module irrigation_timer_sequencer #(
  parameter int unsigned SPRINKLER_MIN = 15,
  parameter int unsigned DRIPPER_MIN   = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       splinker_mode_on,
  input  logic       tick_10s,
  input  logic       conflicting_values,
  input  logic       forced_reset_from_button,
  output logic [1:0] minutes_d,
  output logic [3:0] minutes_u,
  output logic [2:0] seconds_d,
  output logic       valve_on,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [1:0] SPR_D = 2'(SPRINKLER_MIN / 10);
  localparam logic [3:0] SPR_U = 4'(SPRINKLER_MIN % 10);
  localparam logic [1:0] DRI_D = 2'(DRIPPER_MIN / 10);
  localparam logic [3:0] DRI_U = 4'(DRIPPER_MIN % 10);

  state_t     state, state_nxt;
  logic [1:0] md_q, md_d;
  logic [3:0] mu_q, mu_d;
  logic [2:0] sd_q, sd_d;

  // One 10-second step down with BCD-style borrow through the three digits.
  logic [1:0] dec_md;
  logic [3:0] dec_mu;
  logic [2:0] dec_sd;
  logic       dec_zero;

  always_comb begin
    dec_md = md_q;
    dec_mu = mu_q;
    dec_sd = sd_q;
    if (sd_q != 3'd0) begin
      dec_sd = sd_q - 3'd1;
    end else begin
      dec_sd = 3'd5;
      if (mu_q != 4'd0) begin
        dec_mu = mu_q - 4'd1;
      end else begin
        dec_mu = 4'd9;
        dec_md = md_q - 2'd1;
      end
    end
    dec_zero = (dec_md == 2'd0) && (dec_mu == 4'd0) && (dec_sd == 3'd0);
  end

  // Priority: abort, then conflict, then start, then tick.
  always_comb begin
    state_nxt = state;
    md_d      = md_q;
    mu_d      = mu_q;
    sd_d      = sd_q;
    if (forced_reset_from_button) begin
      state_nxt = IDLE;
      md_d      = 2'd0;
      mu_d      = 4'd0;
      sd_d      = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            md_d      = splinker_mode_on ? SPR_D : DRI_D;
            mu_d      = splinker_mode_on ? SPR_U : DRI_U;
            sd_d      = 3'd0;
            state_nxt = conflicting_values ? PAUSE : RUN;
          end
        end
        RUN: begin
          if (conflicting_values) begin
            state_nxt = PAUSE;
          end else if (tick_10s) begin
            md_d = dec_md;
            mu_d = dec_mu;
            sd_d = dec_sd;
            if (dec_zero) state_nxt = DONE;
          end
        end
        PAUSE: begin
          if (!conflicting_values) state_nxt = RUN;
        end
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      md_q  <= 2'd0;
      mu_q  <= 4'd0;
      sd_q  <= 3'd0;
    end else begin
      state <= state_nxt;
      md_q  <= md_d;
      mu_q  <= mu_d;
      sd_q  <= sd_d;
    end
  end

  assign minutes_d = md_q;
  assign minutes_u = mu_q;
  assign seconds_d = sd_q;
  assign valve_on  = (state == RUN);
  assign busy      = (state == RUN) || (state == PAUSE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_irrigation_timer_sequencer.sv
// Bench for irrigation_timer_sequencer: directed scenarios plus random traffic,
// checked against a model that tracks the remaining time as a count of 10-second steps.
module tb_irrigation_timer_sequencer;

  localparam int SPR_MIN = 15;
  localparam int DRI_MIN = 30;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       splinker_mode_on;
  logic       tick_10s;
  logic       conflicting_values;
  logic       forced_reset_from_button;
  logic [1:0] minutes_d;
  logic [3:0] minutes_u;
  logic [2:0] seconds_d;
  logic       valve_on;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  int m_state = M_IDLE;
  int m_rem   = 0;
  int done_seen = 0;

  irrigation_timer_sequencer #(
    .SPRINKLER_MIN(SPR_MIN),
    .DRIPPER_MIN  (DRI_MIN)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .start                   (start),
    .splinker_mode_on        (splinker_mode_on),
    .tick_10s                (tick_10s),
    .conflicting_values      (conflicting_values),
    .forced_reset_from_button(forced_reset_from_button),
    .minutes_d               (minutes_d),
    .minutes_u               (minutes_u),
    .seconds_d               (seconds_d),
    .valve_on                (valve_on),
    .busy                    (busy),
    .done                    (done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [8:0] exp_counter(input int rem);
    logic [1:0] d;
    logic [3:0] u;
    logic [2:0] s;
    d = 2'(rem / 60);
    u = 4'((rem / 6) % 10);
    s = 3'(rem % 6);
    return {d, u, s};
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".counter"}, 16'({minutes_d, minutes_u, seconds_d}), 16'(exp_counter(m_rem)));
    check({tag, ".valve"}, 16'(valve_on), 16'(m_state == M_RUN));
    check({tag, ".busy"}, 16'(busy), 16'(m_state == M_RUN || m_state == M_PAUSE));
    check({tag, ".done"}, 16'(done), 16'(m_state == M_DONE));
  endtask

  // Reference model: one clock edge in terms of remaining 10-second steps.
  task automatic model_edge(input logic s, input logic m, input logic t,
                            input logic c, input logic a);
    if (a) begin
      m_state = M_IDLE;
      m_rem   = 0;
    end else begin
      case (m_state)
        M_IDLE: if (s) begin
          m_rem   = (m ? SPR_MIN : DRI_MIN) * 6;
          m_state = c ? M_PAUSE : M_RUN;
        end
        M_RUN: if (c) m_state = M_PAUSE;
               else if (t) begin
                 m_rem = m_rem - 1;
                 if (m_rem == 0) m_state = M_DONE;
               end
        M_PAUSE: if (!c) m_state = M_RUN;
        default: m_state = M_IDLE;
      endcase
    end
  endtask

  // Driver: apply inputs for one edge, advance model, sample 1 time unit later.
  task automatic step(input string tag, input logic s, input logic m, input logic t,
                      input logic c, input logic a);
    start                    = s;
    splinker_mode_on         = m;
    tick_10s                 = t;
    conflicting_values       = c;
    forced_reset_from_button = a;
    @(posedge clk);
    model_edge(s, m, t, c, a);
    #1;
    if (done) done_seen++;
    check_outputs(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    splinker_mode_on = 1'b0;
    tick_10s = 1'b0;
    conflicting_values = 1'b0;
    forced_reset_from_button = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Sprinkler full run: 90 ticks to done
    done_seen = 0;
    step("spr_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("spr_preset", 16'({minutes_d, minutes_u, seconds_d}), 16'({2'd1, 4'd5, 3'd0}));
    ticks("spr_run", 90);
    step("spr_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("spr_after2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("spr_done_pulses", 16'(done_seen), 16'd1);

    // Dripper borrow chain
    step("dri_start", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks("dri_t1", 1);
    check("dri_295", 16'({minutes_d, minutes_u, seconds_d}), 16'({2'd2, 4'd9, 3'd5}));
    ticks("dri_t5", 5);
    ticks("dri_t6", 1);
    check("dri_285", 16'({minutes_d, minutes_u, seconds_d}), 16'({2'd2, 4'd8, 3'd5}));
    step("dri_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Pause at 1/2/3 for 50 cycles with 5 ticks
    step("pau_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks("pau_pre", 15);
    for (int i = 0; i < 50; i++)
      step("pau_hold", 1'b1, 1'b0, (i % 10) == 0, 1'b1, 1'b0);
    check("pau_123", 16'({minutes_d, minutes_u, seconds_d}), 16'({2'd1, 4'd2, 3'd3}));
    step("pau_release", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks("pau_resume", 2);
    step("pau_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Abort together with the final tick
    step("abt_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks("abt_run", 179);
    done_seen = 0;
    step("abt_last", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("abt_held", 1'b1, i[0], 1'b1, 1'b0, 1'b1);
    step("abt_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("abt_no_done", 16'(done_seen), 16'd0);

    // Start ignored during RUN at 2/0/3
    step("ign_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks("ign_run", 57);
    step("ign_restart", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("ign_restart_tick", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks("ign_cont", 3);
    step("ign_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset between edges
    step("ar_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks("ar_run", 10);
    #2;
    rst_n = 1'b0;
    #1;
    m_state = M_IDLE;
    m_rem   = 0;
    check_outputs("ar_async");
    @(negedge clk);
    rst_n = 1'b1;
    step("ar_restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks("ar_after", 4);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step("rnd",
           $urandom_range(0, 99) < 6,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 199) < 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irrigation_timer_sequencer.md
# irrigation_timer_sequencer

Sequencing controller for the irrigation countdown timer. On a start request it loads the sprinkler (15:00) or dripper (30:00) preset into a minutes-tens / minutes-units / seconds-tens countdown. It decrements that countdown once per 10-second tick and drives the valve while counting. It handles pause on conflicting sensor values and forced abort from the button, and it sits between the mode/sensor logic and the valve driver and display decoders.

## Interface
- `SPRINKLER_MIN`, default 15, sprinkler-mode preset in minutes (BCD 0–39 range; seconds-tens preset is always 0).
- `DRIPPER_MIN`, default 30, dripper-mode preset in minutes (same range rules).
- `clk`  in  1  single system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle irrigation request.
- `splinker_mode_on`  in  1  1 = sprinkler preset, 0 = dripper preset; sampled only on an accepted `start`.
- `tick_10s`  in  1  one-cycle enable, one pulse per 10 s.
- `conflicting_values`  in  1  level; 1 pauses irrigation.
- `forced_reset_from_button`  in  1  level, debounced, active-high abort.
- `minutes_d`  out  2  minutes tens, 0–3.
- `minutes_u`  out  4  minutes units, BCD 0–9.
- `seconds_d`  out  3  seconds tens, 0–5.
- `valve_on`  out  1  open the irrigation valve.
- `busy`  out  1  high in RUN or PAUSE.
- `done`  out  1  one-cycle pulse on natural completion.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Priority per edge, highest first: `forced_reset_from_button`, then `conflicting_values`, then `start`, then `tick_10s`.
- IDLE:
  - `start`=1 and no abort → RUN. The counter loads the preset selected by `splinker_mode_on`: sprinkler = 1/5/0, dripper = 3/0/0 with the default parameters.
  - If `conflicting_values`=1 at that edge, the preset still loads but the state goes to PAUSE.
- RUN:
  - `tick_10s` decrements the counter.
  - Decrement rule: if `seconds_d`>0, decrement it. Otherwise `seconds_d`←5 and borrow from `minutes_u`. If `minutes_u`=0, `minutes_u`←9 and `minutes_d` decrements.
  - A tick that makes the counter 0/0/0 → DONE at the same edge.
- PAUSE: entered from RUN when `conflicting_values`=1. The counter holds and ticks are ignored. `conflicting_values`=0 → RUN.
- DONE: lasts exactly one cycle, then → IDLE. The counter stays at 0/0/0. A `start` in DONE is ignored.
- Abort: `forced_reset_from_button`=1 in any state → IDLE at the next edge. The counter clears to 0/0/0 and no `done` pulse is produced. While the abort is held, IDLE ignores `start`.
- Ignored inputs: `start` in RUN or PAUSE (no reload); `splinker_mode_on` changes outside an accepted `start`.
- Counter never wraps below 0/0/0. A counter already at 0/0/0 in RUN is unreachable, because a zero preset is illegal and parameters must be nonzero.
- Outputs: `valve_on` = (state==RUN); `busy` = RUN|PAUSE; `done` = (state==DONE).

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE; `minutes_d`=0, `minutes_u`=0, `seconds_d`=0; `valve_on`=0, `busy`=0, `done`=0. Release is synchronous to `clk`.
- Reset mid-RUN or mid-PAUSE drops `valve_on` immediately, without waiting for a clock edge.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- `start` at edge N: preset visible and `valve_on`=1 from edge N.
- A `tick_10s` at edge N is not counted when `start` is accepted at edge N; the first decrement is on the next tick.
- Last tick at edge N: counter 0/0/0, `valve_on`=0, `done`=1 for cycle N..N+1. `busy`=0 from N.
- Nominal run: sprinkler = 90 ticks from start to `done`, dripper = 180 ticks, with no pauses.
- `conflicting_values` rising with `tick_10s` at the same edge: pause wins and the tick is lost.
- `conflicting_values` falling: RUN from the next edge; a tick at that same edge is ignored.
- Abort together with the final tick: IDLE, no `done` pulse.

## Test plan
- Sprinkler full run: reset, `splinker_mode_on`=1, pulse `start`, then 90 ticks. Require counter 1/5/0 after start, 0/0/0 after the 90th tick, `done` for exactly 1 cycle, `valve_on` high for the whole run and low after.
- Dripper borrow chain: `splinker_mode_on`=0, start, then 1 tick. Require 3/0/0 → 2/9/5. After 5 more ticks, 2/9/0; after the next tick, 2/8/5.
- Pause: during RUN at 1/2/3, hold `conflicting_values` for 50 cycles with 5 ticks applied. Require counter stays 1/2/3, `valve_on`=0, `busy`=1; RUN resumes one edge after release.
- Abort: at 0/0/1, assert `forced_reset_from_button` on the same edge as a tick. Require IDLE, counter 0/0/0, `done` never asserted, `start` ignored while the button is held.
- Ignored start: pulse `start` with `splinker_mode_on` toggled during RUN at 2/0/3. Require no reload and decrement continues normally.
- Async reset: drop `rst_n` between clock edges during RUN. Require `valve_on`=0 and all counters 0 before the next edge; normal operation after release.
